instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_if.sv | 33 +++
 rtl/instr_fetch_unit.sv | 124 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Signal bundle between the instruction fetch unit, its requester and the byte-wide instruction memory.
// Handshakes: start is taken only while busy=0. mem_rd is a one-cycle strobe with at most one read outstanding,
// and mem_rvalid (with mem_rdata/mem_err) answers it one or more cycles later.
// The result is held on out_valid until a rising edge sees out_valid && out_ready.
interface instr_fetch_unit_if;
   logic        start;
   logic [63:0] pc;
   logic        mem_rd;
   logic [63:0] mem_addr;
   logic        mem_rvalid;
   logic [7:0]  mem_rdata;
   logic        mem_err;
   logic        out_valid;
   logic        out_ready;
   logic [79:0] instr_bytes;
   logic [3:0]  instr_len;
   logic [63:0] valP;
   logic        instr_valid;
   logic        imem_error;
   logic        busy;

   modport slave (
      input  start, pc, mem_rvalid, mem_rdata, mem_err, out_ready,
      output mem_rd, mem_addr, out_valid, instr_bytes, instr_len, valP,
             instr_valid, imem_error, busy
   );

   modport master (
      output start, pc, mem_rvalid, mem_rdata, mem_err, out_ready,
      input  mem_rd, mem_addr, out_valid, instr_bytes, instr_len, valP,
             instr_valid, imem_error, busy
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Byte-serial Y86-64 instruction fetch: reads one byte per request, decodes the length from the first icode,
// and presents the assembled instruction (or a fault) until the consumer accepts it.
module instr_fetch_unit #(
   parameter int unsigned MEM_SIZE = 1024
) (
   input  logic                clk,
   input  logic                reset_n,
   instr_fetch_unit_if.slave   bus,
   output logic [2:0]          dbgState
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } fetchState_t;

   fetchState_t state, nextState;

   logic [63:0] base;
   logic [63:0] addr;
   logic [3:0]  cnt;
   logic [3:0]  cntInc;
   logic [3:0]  lenReg;
   logic [3:0]  lenNow;
   logic [79:0] bytesReg;
   logic        validReg;
   logic        outOfRange;
   logic        rdStrobe;
   logic        byteOk;

   function automatic logic [3:0] decodeLen(input logic [3:0] icode);
      logic [3:0] len;
      case (icode)
         4'h0, 4'h1, 4'h9:        len = 4'd1;
         4'h2, 4'h6, 4'hA, 4'hB:  len = 4'd2;
         4'h7, 4'h8:              len = 4'd9;
         4'h3, 4'h4, 4'h5:        len = 4'd10;
         default:                 len = 4'd1;
      endcase
      return len;
   endfunction

   assign addr       = base + {60'd0, cnt};
   assign outOfRange = (addr >= 64'(MEM_SIZE));
   assign cntInc     = cnt + 4'd1;
   assign byteOk     = bus.mem_rvalid && !bus.mem_err;
   // The length is only known once byte 0 arrives, so that cycle uses the freshly decoded value.
   assign lenNow     = (cnt == 4'd0) ? decodeLen(bus.mem_rdata[7:4]) : lenReg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (bus.start) nextState = ISSUE;
         end
         ISSUE: begin
            nextState = outOfRange ? ERR : WAIT;
         end
         WAIT: begin
            if (bus.mem_rvalid) begin
               if (bus.mem_err)          nextState = ERR;
               else if (cntInc == lenNow) nextState = DONE;
               else                      nextState = ISSUE;
            end
         end
         DONE, ERR: begin
            if (bus.out_ready) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base     <= 64'd0;
         cnt      <= 4'd0;
         bytesReg <= 80'd0;
         lenReg   <= 4'd0;
         validReg <= 1'b0;
      end else begin
         if (state == IDLE && bus.start) begin
            base     <= bus.pc;
            cnt      <= 4'd0;
            bytesReg <= 80'd0;
            lenReg   <= 4'd0;
            validReg <= 1'b0;
         end else if (state == WAIT && byteOk) begin
            for (int k = 0; k < 10; k++) begin
               if (cnt == 4'(k)) bytesReg[k*8 +: 8] <= bus.mem_rdata;
            end
            if (cnt == 4'd0) begin
               lenReg   <= lenNow;
               validReg <= (bus.mem_rdata[7:4] <= 4'hB);
            end
            // On the final byte cnt stays put; in ERR it counts the bytes that did arrive.
            if (cntInc != lenNow) cnt <= cntInc;
         end
      end
   end

   assign rdStrobe         = (state == ISSUE) && !outOfRange;
   assign bus.mem_rd       = rdStrobe;
   assign bus.mem_addr     = rdStrobe ? addr : 64'd0;
   assign bus.out_valid    = (state == DONE) || (state == ERR);
   assign bus.instr_bytes  = bytesReg;
   assign bus.instr_len    = (state == ERR) ? cnt : lenReg;
   assign bus.valP         = (state == ERR) ? base : base + {60'd0, lenReg};
   assign bus.instr_valid  = (state == DONE) && validReg;
   assign bus.imem_error   = (state == ERR);
   assign bus.busy         = (state != IDLE);
   assign dbgState         = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: byte memory responder, per-instruction reference model, per-cycle compare.
module tb_instr_fetch_unit;
   localparam int unsigned MEM_SIZE = 1024;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [2:0] dbgState;

   instr_fetch_unit_if bus();

   instr_fetch_unit #(.MEM_SIZE(MEM_SIZE)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .dbgState (dbgState)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [7:0]  mem [0:MEM_SIZE-1];
   logic [63:0] exp_q[$];
   int          lenTab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};

   logic [79:0] expBytes;
   logic [3:0]  expLen;
   logic [63:0] expValP;
   logic        expValid;
   logic        expErr;
   bit          modelArmed = 1'b0;

   int          respLatency = 1;
   logic [63:0] errAddr = '1;
   int          readCount = 0;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: walk the instruction byte by byte from pc using the length table and the range rule.
   task automatic model_fetch(input logic [63:0] p);
      logic [63:0] a;
      logic [7:0]  b;
      int          k = 0;
      int          len = 0;
      bit          stop = 1'b0;
      expBytes = '0;
      expErr   = 1'b0;
      expValid = 1'b0;
      while (!stop) begin
         a = p + 64'(k);
         if (a >= 64'(MEM_SIZE)) begin
            expErr = 1'b1;
            stop   = 1'b1;
         end else begin
            exp_q.push_back(a);
            if (a == errAddr) begin
               expErr = 1'b1;
               stop   = 1'b1;
            end else begin
               b = mem[a[9:0]];
               expBytes[k*8 +: 8] = b;
               if (k == 0) begin
                  len      = lenTab[b[7:4]];
                  expValid = (b[7:4] <= 4'hB);
               end
               k++;
               if (k == len) stop = 1'b1;
            end
         end
      end
      expLen  = expErr ? 4'(k) : 4'(len);
      expValP = expErr ? p : p + 64'(len);
      if (expErr) expValid = 1'b0;
      modelArmed = 1'b1;
   endtask

   // Memory responder: answers each mem_rd after respLatency cycles and checks the read address order.
   logic [63:0] pendAddr;
   int          pendCnt;
   bit          pendValid;
   initial begin
      bus.mem_rvalid = 1'b0;
      bus.mem_err    = 1'b0;
      bus.mem_rdata  = 8'd0;
      pendValid      = 1'b0;
      pendCnt        = 0;
      pendAddr       = '0;
      forever begin
         @(negedge clk);
         bus.mem_rvalid = 1'b0;
         bus.mem_err    = 1'b0;
         bus.mem_rdata  = 8'd0;
         if (pendValid) begin
            pendCnt--;
            if (pendCnt == 0) begin
               pendValid      = 1'b0;
               bus.mem_rvalid = 1'b1;
               bus.mem_err    = (pendAddr == errAddr);
               bus.mem_rdata  = (pendAddr < 64'(MEM_SIZE)) ? mem[pendAddr[9:0]] : 8'd0;
            end
         end
         if (bus.mem_rd === 1'b1) begin
            readCount++;
            pendAddr  = bus.mem_addr;
            pendValid = 1'b1;
            pendCnt   = respLatency;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_read: got mem_rd at %0h expected no read", bus.mem_addr);
            end else begin
               chk("read_addr", 80'(bus.mem_addr), 80'(exp_q.pop_front()));
            end
         end
      end
   end

   // Every cycle a result is presented it must match the model.
   always @(negedge clk) begin
      if (bus.out_valid === 1'b1) begin
         if (!modelArmed) begin
            checks++;
            errors++;
            $display("FAIL stray_out_valid: got out_valid=1 expected 0");
         end else begin
            chk("cmp_bytes", bus.instr_bytes, expBytes);
            chk("cmp_len", 80'(bus.instr_len), 80'(expLen));
            chk("cmp_valP", 80'(bus.valP), 80'(expValP));
            chk("cmp_instr_valid", 80'(bus.instr_valid), 80'(expValid));
            chk("cmp_imem_error", 80'(bus.imem_error), 80'(expErr));
            chk("cmp_busy", 80'(bus.busy), 80'd1);
         end
      end
   end

   task automatic begin_fetch(input logic [63:0] p);
      readCount = 0;
      model_fetch(p);
      bus.start = 1'b1;
      bus.pc    = p;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (bus.out_valid !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("out_valid_timeout", 80'(bus.out_valid), 80'd1);
   endtask

   task automatic release_result();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      modelArmed = 1'b0;
      chk("drop_out_valid", 80'(bus.out_valid), 80'd0);
      chk("idle_busy", 80'(bus.busy), 80'd0);
      chk("reads_all_issued", 80'(exp_q.size()), 80'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] irm [10];
      logic [7:0] call [9];
      irm  = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      call = '{8'h80, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < int'(MEM_SIZE); i++) mem[i] = 8'd0;
      mem[0] = 8'h10;
      for (int i = 0; i < 10; i++) mem[32'h20 + i] = irm[i];
      mem[1023] = 8'h30;
      mem[32'h40] = 8'hE0;
      mem[32'h50] = 8'h60;
      mem[32'h51] = 8'h23;
      mem[32'h60] = 8'h20;
      mem[32'h61] = 8'h12;
      for (int i = 0; i < 9; i++) mem[32'h70 + i] = call[i];

      bus.start     = 1'b0;
      bus.pc        = '0;
      bus.out_ready = 1'b0;
      reset_n       = 1'b1;
      #1 reset_n    = 1'b0;

      @(negedge clk);
      chk("rst_out_valid", 80'(bus.out_valid), 80'd0);
      chk("rst_mem_rd", 80'(bus.mem_rd), 80'd0);
      chk("rst_mem_addr", 80'(bus.mem_addr), 80'd0);
      chk("rst_instr_bytes", bus.instr_bytes, 80'd0);
      chk("rst_instr_len", 80'(bus.instr_len), 80'd0);
      chk("rst_valP", 80'(bus.valP), 80'd0);
      chk("rst_instr_valid", 80'(bus.instr_valid), 80'd0);
      chk("rst_imem_error", 80'(bus.imem_error), 80'd0);
      chk("rst_busy", 80'(bus.busy), 80'd0);

      // nop at 0, start presented as reset releases
      reset_n = 1'b1;
      begin_fetch(64'h0);
      chk("first_start_busy", 80'(bus.busy), 80'd1);
      wait_valid();
      chk("nop_len", 80'(bus.instr_len), 80'd1);
      chk("nop_valP", 80'(bus.valP), 80'd1);
      chk("nop_bytes", bus.instr_bytes, 80'h10);
      chk("nop_valid", 80'(bus.instr_valid), 80'd1);
      chk("nop_reads", 80'(readCount), 80'd1);
      release_result();

      // irmovq $10,%rdx at 0x20
      begin_fetch(64'h20);
      wait_valid();
      chk("irm_len", 80'(bus.instr_len), 80'd10);
      chk("irm_valP", 80'(bus.valP), 80'h2A);
      chk("irm_byte1", 80'(bus.instr_bytes[15:8]), 80'hF2);
      chk("irm_byte2", 80'(bus.instr_bytes[23:16]), 80'h0A);
      chk("irm_reads", 80'(readCount), 80'd10);
      release_result();

      // straddles the top of memory
      begin_fetch(64'd1023);
      wait_valid();
      chk("edge_imem_error", 80'(bus.imem_error), 80'd1);
      chk("edge_len", 80'(bus.instr_len), 80'd1);
      chk("edge_valP", 80'(bus.valP), 80'd1023);
      chk("edge_bytes", bus.instr_bytes, 80'h30);
      chk("edge_reads", 80'(readCount), 80'd1);
      release_result();

      // invalid icode
      begin_fetch(64'h40);
      wait_valid();
      chk("bad_len", 80'(bus.instr_len), 80'd1);
      chk("bad_instr_valid", 80'(bus.instr_valid), 80'd0);
      chk("bad_imem_error", 80'(bus.imem_error), 80'd0);
      release_result();

      // memory fault on byte 1 of an OPq
      errAddr = 64'h51;
      begin_fetch(64'h50);
      wait_valid();
      chk("fault_imem_error", 80'(bus.imem_error), 80'd1);
      chk("fault_len", 80'(bus.instr_len), 80'd1);
      chk("fault_valP", 80'(bus.valP), 80'h50);
      chk("fault_reads", 80'(readCount), 80'd2);
      release_result();
      errAddr = '1;

      // backpressure with start pulses while the result is held
      begin_fetch(64'h60);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         bus.start = (i % 2 == 0);
         bus.pc    = 64'h100 + 64'(i);
         @(negedge clk);
         chk("bp_out_valid", 80'(bus.out_valid), 80'd1);
         chk("bp_bytes", bus.instr_bytes, 80'h1220);
         chk("bp_valP", 80'(bus.valP), 80'h62);
      end
      bus.start = 1'b0;
      chk("bp_reads", 80'(readCount), 80'd2);
      release_result();

      // reset while waiting on byte 1 of a call; its late response must be ignored
      respLatency = 3;
      begin_fetch(64'h70);
      begin
         int n = 0;
         while (readCount < 2 && n < 100) begin
            @(negedge clk);
            n++;
         end
         chk("call_second_read", 80'(readCount), 80'd2);
      end
      @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 80'(bus.out_valid), 80'd0);
      chk("mid_rst_busy", 80'(bus.busy), 80'd0);
      chk("mid_rst_mem_rd", 80'(bus.mem_rd), 80'd0);
      chk("mid_rst_len", 80'(bus.instr_len), 80'd0);
      modelArmed = 1'b0;
      exp_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("late_rvalid_busy", 80'(bus.busy), 80'd0);
      chk("late_rvalid_out_valid", 80'(bus.out_valid), 80'd0);
      chk("late_rvalid_reads", 80'(readCount), 80'd2);
      respLatency = 1;
      begin_fetch(64'h0);
      wait_valid();
      chk("post_rst_len", 80'(bus.instr_len), 80'd1);
      chk("post_rst_valP", 80'(bus.valP), 80'd1);
      chk("post_rst_bytes", bus.instr_bytes, 80'h10);
      chk("post_rst_valid", 80'(bus.instr_valid), 80'd1);
      release_result();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
